// File: rtl/scan_decoder_pkg.sv
// Shared types for the scan decoder: FSM state encoding and mode-select constants.
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/dwell_counter.sv
// Dwell timer: counts 0..DWELL-1 and raises tick_out combinationally on the last count.
// No flow control; clear restarts the count from zero on the next edge.
module dwell_counter #(
    parameter int unsigned DWELL = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick_out
);

    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_out = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || tick_out) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// One-hot line decoder with direct (load-strobed) and auto-scan modes.
// All outputs registered, 1-cycle latency from load/mode/enable; no backpressure.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned DWELL = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  mode,
    input  logic                  load,
    input  logic [SEL_W-1:0]      data_in,
    output logic [(2**SEL_W)-1:0] data_out,
    output logic [SEL_W-1:0]      sel_out,
    output logic                  valid,
    output logic                  wrap
);

    localparam int unsigned LINES = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] SEL_MAX = {SEL_W{1'b1}};

    state_t             state_q, state_d;
    logic [LINES-1:0]   data_q,  data_d;
    logic [SEL_W-1:0]   sel_q,   sel_d;
    logic               valid_q, valid_d;
    logic               wrap_q,  wrap_d;
    logic               dwell_clear;
    logic               dwell_tick;

    // The timer only runs while the FSM stays in SCAN, so every scan entry starts a fresh dwell.
    assign dwell_clear = !((state_q == SCAN) && (state_d == SCAN));

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk      (clk),
        .reset    (reset),
        .clear    (dwell_clear),
        .tick_out (dwell_tick)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            sel_d   = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    sel_d = '0;
                    if (mode == MODE_SCAN) begin
                        state_d = SCAN;
                        valid_d = 1'b1;
                    end else begin
                        state_d = DIRECT;
                        valid_d = 1'b0;
                    end
                end
                DIRECT: begin
                    if (mode == MODE_SCAN) begin
                        state_d = SCAN;
                        sel_d   = '0;
                        valid_d = 1'b1;
                    end else if (load) begin
                        sel_d   = data_in;
                        valid_d = 1'b1;
                    end
                end
                SCAN: begin
                    if (mode == MODE_DIRECT) begin
                        state_d = DIRECT;
                        sel_d   = '0;
                        valid_d = 1'b0;
                    end else if (dwell_tick) begin
                        sel_d  = sel_q + SEL_W'(1);
                        wrap_d = (sel_q == SEL_MAX);
                    end
                end
                default: begin
                    state_d = IDLE;
                    sel_d   = '0;
                    valid_d = 1'b0;
                end
            endcase
        end

        // Decode by shifting a single bit; a cleared valid yields all zeros.
        data_d = LINES'(valid_d) << sel_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign data_out = data_q;
    assign sel_out  = sel_q;
    assign valid    = valid_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed-vector bench for scan_decoder across four parameterisations.
module tb_scan_decoder;
    import scan_decoder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // a: SEL_W=3 DWELL=4   b: SEL_W=3 DWELL=1   c: SEL_W=4 DWELL=4   d: SEL_W=1 DWELL=1
    logic       a_reset, a_enable, a_mode, a_load;
    logic [2:0] a_din;
    logic [7:0] a_data;
    logic [2:0] a_sel;
    logic       a_valid, a_wrap;

    logic       b_reset, b_enable, b_mode, b_load;
    logic [2:0] b_din;
    logic [7:0] b_data;
    logic [2:0] b_sel;
    logic       b_valid, b_wrap;

    logic        c_reset, c_enable, c_mode, c_load;
    logic [3:0]  c_din;
    logic [15:0] c_data;
    logic [3:0]  c_sel;
    logic        c_valid, c_wrap;

    logic       d_reset, d_enable, d_mode, d_load;
    logic [0:0] d_din;
    logic [1:0] d_data;
    logic [0:0] d_sel;
    logic       d_valid, d_wrap;

    scan_decoder #(.SEL_W(3), .DWELL(4)) u_a (
        .clk(clk), .reset(a_reset), .enable(a_enable), .mode(a_mode), .load(a_load),
        .data_in(a_din), .data_out(a_data), .sel_out(a_sel), .valid(a_valid), .wrap(a_wrap)
    );
    scan_decoder #(.SEL_W(3), .DWELL(1)) u_b (
        .clk(clk), .reset(b_reset), .enable(b_enable), .mode(b_mode), .load(b_load),
        .data_in(b_din), .data_out(b_data), .sel_out(b_sel), .valid(b_valid), .wrap(b_wrap)
    );
    scan_decoder #(.SEL_W(4), .DWELL(4)) u_c (
        .clk(clk), .reset(c_reset), .enable(c_enable), .mode(c_mode), .load(c_load),
        .data_in(c_din), .data_out(c_data), .sel_out(c_sel), .valid(c_valid), .wrap(c_wrap)
    );
    scan_decoder #(.SEL_W(1), .DWELL(1)) u_d (
        .clk(clk), .reset(d_reset), .enable(d_enable), .mode(d_mode), .load(d_load),
        .data_in(d_din), .data_out(d_data), .sel_out(d_sel), .valid(d_valid), .wrap(d_wrap)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_reset = 1'b1; a_enable = 1'b1; a_mode = MODE_SCAN; a_load = 1'b1; a_din = 3'd5;
        step();
        checks++;
        if (a_data !== 8'h00 || a_sel !== 3'd0 || a_valid !== 1'b0 || a_wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_a got data=%h sel=%0d valid=%b wrap=%b want 00/0/0/0", a_data, a_sel, a_valid, a_wrap);
        end
        checks++;
        if (b_data !== 8'h00 || c_data !== 16'h0000 || d_data !== 2'b00 || b_valid !== 1'b0 || c_valid !== 1'b0 || d_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_others got b=%h c=%h d=%b valids=%b%b%b want zeros", b_data, c_data, d_data, b_valid, c_valid, d_valid);
        end
        a_reset = 1'b0; a_enable = 1'b0;
        step();
        checks++;
        if (a_data !== 8'h00 || a_valid !== 1'b0 || a_wrap !== 1'b0) begin
            errors++;
            $display("FAIL disabled_idle got data=%h valid=%b wrap=%b want 00/0/0", a_data, a_valid, a_wrap);
        end
    endtask

    task automatic test_direct();
        a_enable = 1'b1; a_mode = MODE_DIRECT; a_load = 1'b0;
        step();
        checks++;
        if (a_data !== 8'h00 || a_sel !== 3'd0 || a_valid !== 1'b0) begin
            errors++;
            $display("FAIL direct_entry got data=%h sel=%0d valid=%b want 00/0/0", a_data, a_sel, a_valid);
        end
        a_load = 1'b1; a_din = 3'd5;
        step();
        checks++;
        if (a_data !== 8'b0010_0000 || a_sel !== 3'd5 || a_valid !== 1'b1) begin
            errors++;
            $display("FAIL direct_load5 got data=%h sel=%0d valid=%b want 20/5/1", a_data, a_sel, a_valid);
        end
        a_load = 1'b0; a_din = 3'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (a_data !== 8'b0010_0000 || a_sel !== 3'd5 || a_valid !== 1'b1) begin
                errors++;
                $display("FAIL direct_hold cyc=%0d got data=%h sel=%0d valid=%b want 20/5/1", i, a_data, a_sel, a_valid);
            end
        end
    endtask

    task automatic test_scan_sweep();
        logic [7:0] exp_d;
        int line;
        a_mode = MODE_SCAN; a_load = 1'b1; a_din = 3'd7;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            step();
            line = ((cyc - 1) / 4) % 8;
            exp_d = 8'd1 << line;
            checks++;
            if (a_data !== exp_d || a_sel !== 3'(line) || a_valid !== 1'b1 || a_wrap !== (cyc == 33)) begin
                errors++;
                $display("FAIL scan_sweep cyc=%0d got data=%h sel=%0d valid=%b wrap=%b want %h/%0d/1/%b",
                         cyc, a_data, a_sel, a_valid, a_wrap, exp_d, line, (cyc == 33));
            end
        end
        a_load = 1'b0;
    endtask

    task automatic test_enable_drop();
        a_enable = 1'b0;
        step();
        a_enable = 1'b1;
        step();
        repeat (12) step();
        checks++;
        if (a_data !== 8'h08 || a_sel !== 3'd3) begin
            errors++;
            $display("FAIL reach_line3 got data=%h sel=%0d want 08/3", a_data, a_sel);
        end
        a_enable = 1'b0;
        step();
        checks++;
        if (a_data !== 8'h00 || a_sel !== 3'd0 || a_valid !== 1'b0 || a_wrap !== 1'b0) begin
            errors++;
            $display("FAIL enable_drop got data=%h sel=%0d valid=%b wrap=%b want 00/0/0/0", a_data, a_sel, a_valid, a_wrap);
        end
        a_enable = 1'b1;
        step();
        checks++;
        if (a_data !== 8'h01 || a_sel !== 3'd0 || a_valid !== 1'b1 || a_wrap !== 1'b0) begin
            errors++;
            $display("FAIL scan_reentry got data=%h sel=%0d valid=%b wrap=%b want 01/0/1/0", a_data, a_sel, a_valid, a_wrap);
        end
        repeat (3) step();
        checks++;
        if (a_sel !== 3'd0) begin
            errors++;
            $display("FAIL dwell_line0 got sel=%0d want 0", a_sel);
        end
        step();
        checks++;
        if (a_data !== 8'h02 || a_sel !== 3'd1) begin
            errors++;
            $display("FAIL dwell_line1 got data=%h sel=%0d want 02/1", a_data, a_sel);
        end
    endtask

    task automatic test_mode_switch();
        repeat (20) step();
        checks++;
        if (a_data !== 8'h40 || a_sel !== 3'd6) begin
            errors++;
            $display("FAIL reach_line6 got data=%h sel=%0d want 40/6", a_data, a_sel);
        end
        a_mode = MODE_DIRECT;
        step();
        checks++;
        if (a_data !== 8'h00 || a_sel !== 3'd0 || a_valid !== 1'b0) begin
            errors++;
            $display("FAIL scan_to_direct got data=%h sel=%0d valid=%b want 00/0/0", a_data, a_sel, a_valid);
        end
        a_load = 1'b1; a_din = 3'd2;
        step();
        checks++;
        if (a_data !== 8'b0000_0100 || a_sel !== 3'd2 || a_valid !== 1'b1) begin
            errors++;
            $display("FAIL direct_load2 got data=%h sel=%0d valid=%b want 04/2/1", a_data, a_sel, a_valid);
        end
        a_load = 1'b0; a_mode = MODE_SCAN;
        step();
        checks++;
        if (a_data !== 8'h01 || a_sel !== 3'd0 || a_valid !== 1'b1 || a_wrap !== 1'b0) begin
            errors++;
            $display("FAIL direct_to_scan got data=%h sel=%0d valid=%b wrap=%b want 01/0/1/0", a_data, a_sel, a_valid, a_wrap);
        end
    endtask

    task automatic test_dwell1_reset();
        logic [7:0] exp_d;
        int line;
        b_reset = 1'b0; b_enable = 1'b1; b_mode = MODE_SCAN; b_load = 1'b0; b_din = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            step();
            line = k - 1;
            exp_d = 8'd1 << line;
            checks++;
            if (b_data !== exp_d || b_sel !== 3'(line) || b_valid !== 1'b1 || b_wrap !== 1'b0) begin
                errors++;
                $display("FAIL dwell1_sweep k=%0d got data=%h sel=%0d valid=%b wrap=%b want %h/%0d/1/0",
                         k, b_data, b_sel, b_valid, b_wrap, exp_d, line);
            end
        end
        b_reset = 1'b1;
        step();
        checks++;
        if (b_data !== 8'h00 || b_sel !== 3'd0 || b_valid !== 1'b0 || b_wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_midscan got data=%h sel=%0d valid=%b wrap=%b want 00/0/0/0", b_data, b_sel, b_valid, b_wrap);
        end
        b_reset = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            line = (k - 1) % 8;
            exp_d = 8'd1 << line;
            checks++;
            if (b_data !== exp_d || b_sel !== 3'(line) || b_valid !== 1'b1 || b_wrap !== (k == 9)) begin
                errors++;
                $display("FAIL dwell1_restart k=%0d got data=%h sel=%0d valid=%b wrap=%b want %h/%0d/1/%b",
                         k, b_data, b_sel, b_valid, b_wrap, exp_d, line, (k == 9));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_d;
        c_reset = 1'b0; c_enable = 1'b1; c_mode = MODE_DIRECT; c_load = 1'b0; c_din = 4'd0;
        step();
        checks++;
        if (c_data !== 16'h0000 || c_valid !== 1'b0) begin
            errors++;
            $display("FAIL c_direct_entry got data=%h valid=%b want 0000/0", c_data, c_valid);
        end
        for (int v = 0; v < 16; v++) begin
            c_load = 1'b1; c_din = 4'(v);
            step();
            exp_d = 16'd1 << v;
            checks++;
            if (c_data !== exp_d || c_sel !== 4'(v) || c_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_load v=%0d got data=%h sel=%0d valid=%b want %h/%0d/1", v, c_data, c_sel, c_valid, exp_d, v);
            end
        end
        c_load = 1'b0; c_din = 4'd3;
        step();
        checks++;
        if (c_data !== 16'h8000 || c_sel !== 4'd15 || c_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_hold got data=%h sel=%0d valid=%b want 8000/15/1", c_data, c_sel, c_valid);
        end
    endtask

    task automatic test_sel1();
        logic [1:0] exp_d;
        int line;
        d_reset = 1'b0; d_enable = 1'b1; d_mode = MODE_SCAN; d_load = 1'b0; d_din = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            line = (k - 1) % 2;
            exp_d = 2'd1 << line;
            checks++;
            if (d_data !== exp_d || d_sel !== 1'(line) || d_valid !== 1'b1 || d_wrap !== (k >= 3 && line == 0)) begin
                errors++;
                $display("FAIL sel1_alt k=%0d got data=%b sel=%0d valid=%b wrap=%b want %b/%0d/1/%b",
                         k, d_data, d_sel, d_valid, d_wrap, exp_d, line, (k >= 3 && line == 0));
            end
        end
    endtask

    initial begin
        a_reset = 1'b1; a_enable = 1'b0; a_mode = 1'b0; a_load = 1'b0; a_din = '0;
        b_reset = 1'b1; b_enable = 1'b0; b_mode = 1'b0; b_load = 1'b0; b_din = '0;
        c_reset = 1'b1; c_enable = 1'b0; c_mode = 1'b0; c_load = 1'b0; c_din = '0;
        d_reset = 1'b1; d_enable = 1'b0; d_mode = 1'b0; d_load = 1'b0; d_din = '0;
        test_reset();
        test_direct();
        test_scan_sweep();
        test_enable_drop();
        test_mode_switch();
        test_dwell1_reset();
        test_back_to_back();
        test_sel1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
